// File: rtl/io_psw_port.sv
// Push-switch IO responder: synchronizes and debounces 20 switches, latches
// sticky press/release events, counts presses and drives a maskable IRQ level.
module io_psw_port #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic        CLK,
  input  logic        N_RST,
  input  logic [4:0]  PSW_A,
  input  logic [4:0]  PSW_B,
  input  logic [4:0]  PSW_C,
  input  logic [4:0]  PSW_D,
  input  logic        IOS,
  input  logic [3:0]  IOA,
  input  logic [31:0] IOD,
  input  logic        IOE,
  output logic [31:0] IOQ,
  output logic        IRQ
);

  localparam int NSW = 20;
  localparam logic [15:0] TICK_LAST = 16'(DEBOUNCE_CYCLES - 1);

  localparam logic [3:0] A_SYNC    = 4'd0;
  localparam logic [3:0] A_LEVEL   = 4'd1;
  localparam logic [3:0] A_PRESS   = 4'd2;
  localparam logic [3:0] A_RELEASE = 4'd3;
  localparam logic [3:0] A_MASK    = 4'd4;
  localparam logic [3:0] A_COUNT   = 4'd5;

  logic [NSW-1:0] raw;
  logic [NSW-1:0] meta_q, meta_d;
  logic [NSW-1:0] sync_q, sync_d;
  logic [15:0]    pre_q, pre_d;
  logic [NSW-1:0] h0_q, h0_d;
  logic [NSW-1:0] h1_q, h1_d;
  logic [NSW-1:0] h2_q, h2_d;
  logic [NSW-1:0] level_q, level_d;
  logic [NSW-1:0] press_q, press_d;
  logic [NSW-1:0] release_q, release_d;
  logic [NSW-1:0] mask_q, mask_d;
  logic [15:0]    count_q, count_d;
  logic           irq_q, irq_d;

  logic           tick;
  logic           wr;
  logic [NSW-1:0] rise;
  logic [NSW-1:0] fall;
  logic [NSW-1:0] clr_press;
  logic [NSW-1:0] clr_release;
  logic           unused_iod;

  assign raw        = {PSW_D, PSW_C, PSW_B, PSW_A};
  assign tick       = (pre_q == TICK_LAST);
  assign wr         = IOS & IOE;
  assign unused_iod = ^IOD[31:NSW];

  always_comb begin
    meta_d = raw;
    sync_d = meta_q;
    pre_d  = tick ? 16'd0 : pre_q + 16'd1;

    h0_d    = h0_q;
    h1_d    = h1_q;
    h2_d    = h2_q;
    level_d = level_q;
    if (tick) begin
      h0_d = sync_q;
      h1_d = h0_q;
      h2_d = h1_q;
      // New history is {h1,h0,sync}: all ones sets, all zeros clears, else hold.
      level_d = (level_q | (sync_q & h0_q & h1_q)) & (sync_q | h0_q | h1_q);
    end

    rise = level_d & ~level_q;
    fall = ~level_d & level_q;
  end

  always_comb begin
    clr_press   = '0;
    clr_release = '0;
    if (wr && IOA == A_PRESS)   clr_press   = IOD[NSW-1:0];
    if (wr && IOA == A_RELEASE) clr_release = IOD[NSW-1:0];

    // A new event on the same edge as its W1C clear must survive.
    press_d   = (press_q & ~clr_press) | rise;
    release_d = (release_q & ~clr_release) | fall;

    mask_d = mask_q;
    if (wr && IOA == A_MASK) mask_d = IOD[NSW-1:0];

    count_d = count_q;
    if (wr && IOA == A_COUNT) begin
      count_d = (|rise) ? 16'd1 : 16'd0;
    end else if ((|rise) && count_q != 16'hFFFF) begin
      count_d = count_q + 16'd1;
    end

    irq_d = |(press_q & mask_q);
  end

  always_ff @(posedge CLK or negedge N_RST) begin
    if (!N_RST) begin
      meta_q    <= '0;
      sync_q    <= '0;
      pre_q     <= '0;
      h0_q      <= '0;
      h1_q      <= '0;
      h2_q      <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      mask_q    <= '0;
      count_q   <= '0;
      irq_q     <= 1'b0;
    end else begin
      meta_q    <= meta_d;
      sync_q    <= sync_d;
      pre_q     <= pre_d;
      h0_q      <= h0_d;
      h1_q      <= h1_d;
      h2_q      <= h2_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      mask_q    <= mask_d;
      count_q   <= count_d;
      irq_q     <= irq_d;
    end
  end

  // h2 is kept as the architectural oldest sample; the set/clear test only
  // needs the two newer samples plus the incoming one.
  logic unused_h2;
  assign unused_h2 = ^h2_q;

  always_comb begin
    IOQ = 32'd0;
    if (IOS) begin
      case (IOA)
        A_SYNC:    IOQ = {12'd0, sync_q};
        A_LEVEL:   IOQ = {12'd0, level_q};
        A_PRESS:   IOQ = {12'd0, press_q};
        A_RELEASE: IOQ = {12'd0, release_q};
        A_MASK:    IOQ = {12'd0, mask_q};
        A_COUNT:   IOQ = {16'd0, count_q};
        default:   IOQ = 32'd0;
      endcase
    end
  end

  assign IRQ = irq_q;

endmodule
